mem_dump_uart_tx: RTL and testbench
===================================

MEM_DUMP_UART_TX -- requirements
Module: mem_dump_uart_tx

Interface
REQ-001 Parameter: BAUD_DIV, 1042, clock cycles per UART bit (9600 baud at 10 MHz); legal range 4..65535.
REQ-002 Parameter: ADR_W, 14, memory word-address width.
REQ-003 Port: clock  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  single-cycle request to begin a dump.
REQ-006 Port: abort  input  1  cancels an active dump.
REQ-007 Port: base_adr  input  ADR_W  first word address, sampled on accepted start.
REQ-008 Port: word_count  input  ADR_W+1  number of words to send, sampled on accepted start.
REQ-009 Port: mem_rd_en  output  1  memory read strobe.
REQ-010 Port: mem_adr  output  ADR_W  memory word address.
REQ-011 Port: mem_dat  input  32  read data, valid exactly one cycle after mem_rd_en.
REQ-012 Port: tx  output  1  UART serial out, 8N1, idle high.
REQ-013 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-014 Port: done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, CAPTURE, START, DATA, STOP, and FIN.
REQ-016 IDLE: start=1 SHALL be accepted, latching base_adr/word_count; start while busy SHALL be ignored.
REQ-017 Accepted start with word_count=0 SHALL go to FIN directly: no mem_rd_en, tx stays high.
REQ-018 FETCH: mem_rd_en=1 for exactly one cycle with mem_adr=current address; next state CAPTURE.
REQ-019 CAPTURE: mem_dat SHALL be latched into a 32-bit shift word, byte index set to 0; next state START.
REQ-020 START: tx=0 for BAUD_DIV cycles; DATA: 8 bits, LSB first, each held BAUD_DIV cycles; STOP: tx=1 for BAUD_DIV cycles.
REQ-021 Bytes of each word SHALL be sent little-endian: [7:0], [15:8], [23:16], [31:24].
REQ-022 After STOP: byte index<3 -> START with next byte; byte index=3 and words remaining>1 -> FETCH with address+1; last word -> FIN.
REQ-023 Address increment SHALL wrap modulo 2^ADR_W (max address -> 0) without error.
REQ-024 FIN: done=1 for one cycle, busy=0 from that cycle; next state IDLE.
REQ-025 Frame length SHALL be exactly 10*BAUD_DIV cycles; inter-byte gap within a word SHALL be 0 cycles; inter-word gap SHALL be exactly 2 cycles (FETCH, CAPTURE).
REQ-026 abort while busy SHALL go to IDLE on the next edge: tx=1, busy=0, done not asserted; a partial frame SHALL be truncated.
REQ-027 abort and start asserted in the same IDLE cycle: abort SHALL win, start ignored.
REQ-028 mem_rd_en SHALL be 0 outside FETCH; mem_adr SHALL hold its last value otherwise.
REQ-029 The baud counter SHALL reload at every state/bit transition so that no bit is shortened.

Reset
REQ-030 On reset: state=IDLE, tx=1, busy=0, done=0, mem_rd_en=0, mem_adr=0, counters=0.
REQ-031 reset SHALL override start and abort; reset mid-frame SHALL drive tx=1 on the next edge.

Verification
REQ-032 BAUD_DIV=4, start with base_adr=0x0010, word_count=1, mem[0x10]=0x44332211 -> one mem_rd_en at adr 0x10; bytes 0x11,0x22,0x33,0x44 decoded; done one cycle after the last stop bit; total 160+3 cycles.
REQ-033 base_adr=0x3FFF, word_count=2 -> reads at 0x3FFF then 0x0000; 8 bytes; 2-cycle gap between words.
REQ-034 word_count=0 -> done pulse 1 cycle after start, tx constant 1, no mem_rd_en.
REQ-035 abort during DATA bit 3 of byte 2 -> tx=1 next cycle, busy=0, no done; a new start then dumps correctly.
REQ-036 start re-pulsed while busy, and start+abort together in IDLE -> both ignored, output stream unchanged.
REQ-037 reset during a STOP bit -> all outputs at reset values next cycle; UART monitor sees no further bytes.

Source files
------------

// File: rtl/mem_dump_uart_tx.sv
// Reads a block of 32-bit memory words and sends each one as four 8N1 UART bytes, least significant byte first.
// States: IDLE -> FETCH -> CAPTURE -> START -> DATA -> STOP -> (START | FETCH | FIN) -> IDLE.
module mem_dump_uart_tx #(
  parameter int BAUD_DIV = 1042,
  parameter int ADR_W    = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [ADR_W:0]   word_count,
  output logic             mem_rd_en,
  output logic [ADR_W-1:0] mem_adr,
  input  logic [31:0]      mem_dat,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, START, DATA, STOP, FIN
  } state_t;

  localparam logic [15:0]    BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [ADR_W:0] ONE_WORD    = {{ADR_W{1'b0}}, 1'b1};

  state_t           state_q;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic             cnt_tc;
  logic [2:0]       bit_q;
  logic [1:0]       byte_q;
  logic [31:0]      shift_q;
  logic [ADR_W-1:0] adr_q;
  logic [ADR_W:0]   left_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             rd_en_q;

  // Down-counter: every bit period spans the terminal count plus BAUD_DIV-1 reload steps.
  assign cnt_tc = (cnt_q == 16'd0);
  assign cnt_d  = cnt_tc ? BAUD_RELOAD : cnt_q - 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      adr_q   <= '0;
      left_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        tx_q    <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              left_q <= word_count;
              if (word_count == '0) begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end else begin
                adr_q   <= base_adr;
                rd_en_q <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= FETCH;
              end
            end
          end
          FETCH: state_q <= CAPTURE;
          CAPTURE: begin
            shift_q <= mem_dat;
            byte_q  <= 2'd0;
            tx_q    <= 1'b0;
            cnt_q   <= BAUD_RELOAD;
            state_q <= START;
          end
          START: begin
            cnt_q <= cnt_d;
            if (cnt_tc) begin
              tx_q    <= shift_q[0];
              bit_q   <= 3'd0;
              state_q <= DATA;
            end
          end
          DATA: begin
            cnt_q <= cnt_d;
            if (cnt_tc) begin
              // Shifting once per bit leaves the next byte in [7:0] after eight bits.
              shift_q <= shift_q >> 1;
              if (bit_q == 3'd7) begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end else begin
                tx_q  <= shift_q[1];
                bit_q <= bit_q + 3'd1;
              end
            end
          end
          STOP: begin
            cnt_q <= cnt_d;
            if (cnt_tc) begin
              if (byte_q != 2'd3) begin
                byte_q  <= byte_q + 2'd1;
                tx_q    <= 1'b0;
                state_q <= START;
              end else if (left_q != ONE_WORD) begin
                left_q  <= left_q - ONE_WORD;
                adr_q   <= adr_q + 1'b1;
                rd_en_q <= 1'b1;
                state_q <= FETCH;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= FIN;
              end
            end
          end
          FIN:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_adr   = adr_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_dump_uart_tx.sv
// Directed and randomized dumps checked against a word-list/byte-queue model and a behavioural UART receiver.
module tb_mem_dump_uart_tx;
  localparam int BAUD = 4;
  localparam int AW   = 14;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_adr;
  logic [AW:0]   word_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_dat;
  logic          tx;
  logic          busy;
  logic          done;

  mem_dump_uart_tx #(.BAUD_DIV(BAUD), .ADR_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .base_adr(base_adr), .word_count(word_count),
    .mem_rd_en(mem_rd_en), .mem_adr(mem_adr), .mem_dat(mem_dat),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clock) if (mem_rd_en) mem_dat <= mem[mem_adr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0]    rx_q[$];
  int            st_q[$];
  logic [AW-1:0] rd_q[$];
  int            done_cnt  = 0;
  int            frame_err = 0;

  always @(negedge clock) begin
    if (mem_rd_en === 1'b1) rd_q.push_back(mem_adr);
    if (done === 1'b1) done_cnt++;
  end

  // Receiver: samples mid-bit, starting from the first low cycle of a start bit.
  always begin : uart_mon
    logic [7:0] b;
    logic       sb, pb;
    @(negedge clock);
    if (tx === 1'b0) begin
      st_q.push_back(cyc);
      repeat (BAUD/2) @(negedge clock);
      sb = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clock);
        b[i] = tx;
      end
      repeat (BAUD) @(negedge clock);
      pb = tx;
      if (sb === 1'b0 && pb === 1'b1) rx_q.push_back(b);
      else frame_err++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0]    exp_bytes[$];
  logic [AW-1:0] exp_rd[$];

  task automatic build_expect(input logic [AW-1:0] b, input int wc);
    logic [AW-1:0] a;
    logic [31:0]   w;
    exp_bytes.delete();
    exp_rd.delete();
    for (int i = 0; i < wc; i++) begin
      a = AW'((int'(b) + i) % (1 << AW));
      exp_rd.push_back(a);
      w = mem[a];
      for (int k = 0; k < 4; k++) exp_bytes.push_back(w[8*k +: 8]);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    st_q.delete();
    rd_q.delete();
    done_cnt  = 0;
    frame_err = 0;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_nreads"}, 64'(rd_q.size()), 64'(exp_rd.size()));
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      check({tag, "_rdadr"}, 64'(rd_q[i]), 64'(exp_rd[i]));
    check({tag, "_nbytes"}, 64'(rx_q.size()), 64'(exp_bytes.size()));
    for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++)
      check({tag, "_byte"}, 64'(rx_q[i]), 64'(exp_bytes[i]));
    check({tag, "_framing"}, 64'(frame_err), 64'd0);
    for (int i = 1; i < st_q.size(); i++)
      check({tag, "_gap"}, 64'(st_q[i] - st_q[i-1]), (i % 4 == 0) ? 64'd42 : 64'd40);
  endtask

  // One complete dump; done is expected 162*wc+1 cycles after the accepting edge.
  task automatic run_dump(input string tag, input logic [AW-1:0] b, input int wc, input bit repulse);
    int total, done_at;
    clear_mon();
    build_expect(b, wc);
    @(negedge clock);
    base_adr = b; word_count = (AW+1)'(wc); start = 1'b1;
    @(negedge clock);
    start = 1'b0; base_adr = AW'($urandom); word_count = (AW+1)'($urandom_range(1, 5));
    check({tag, "_busy_first"}, 64'(busy), (wc > 0) ? 64'd1 : 64'd0);
    total   = 162*wc + 1;
    done_at = -1;
    for (int k = 1; k <= total + 60; k++) begin
      if (k > 1) @(negedge clock);
      if (done === 1'b1 && done_at < 0) begin
        done_at = k;
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      end
      start = (repulse && k == 50) ? 1'b1 : 1'b0;
    end
    check({tag, "_done_time"}, 64'(done_at), 64'(total));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    compare_stream(tag);
  endtask

  initial begin
    int timeout;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[14'h0010] = 32'h44332211;
    reset = 1'b1; start = 1'b0; abort = 1'b0; base_adr = '0; word_count = '0;
    repeat (3) @(negedge clock);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_adr", 64'(mem_adr), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    run_dump("single", 14'h0010, 1, 1'b0);
    check("single_b0", 64'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 64'h11);
    check("single_b3", 64'(rx_q.size() > 3 ? rx_q[3] : 8'h00), 64'h44);

    run_dump("wrap", 14'h3FFF, 2, 1'b0);
    check("wrap_second_adr", 64'(rd_q.size() > 1 ? rd_q[1] : 14'h1234), 64'd0);

    run_dump("zero", AW'($urandom), 0, 1'b0);
    check("zero_no_tx", 64'(st_q.size()), 64'd0);

    run_dump("repulse", AW'($urandom), 2, 1'b1);
    for (int r = 0; r < 3; r++)
      run_dump("random", AW'($urandom), $urandom_range(1, 3), 1'b0);

    // Abort during bit 3 of the third byte, 100 cycles after the start request.
    clear_mon();
    base_adr = AW'($urandom);
    build_expect(base_adr, 2);
    @(negedge clock);
    word_count = 15'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (98) @(negedge clock);
    check("abort_bit3", 64'(tx), 64'(exp_bytes[2][3]));
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_tx", 64'(tx), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (60) @(negedge clock);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_nbytes", 64'(rx_q.size()), 64'd3);
    check("abort_b0", 64'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 64'(exp_bytes[0]));
    check("abort_b1", 64'(rx_q.size() > 1 ? rx_q[1] : 8'h00), 64'(exp_bytes[1]));
    run_dump("after_abort", AW'($urandom), 1, 1'b0);

    // start and abort together in IDLE
    clear_mon();
    @(negedge clock);
    start = 1'b1; abort = 1'b1; base_adr = AW'($urandom); word_count = 15'd1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    check("both_busy", 64'(busy), 64'd0);
    repeat (30) @(negedge clock);
    check("both_reads", 64'(rd_q.size()), 64'd0);
    check("both_frames", 64'(st_q.size()), 64'd0);
    check("both_done", 64'(done_cnt), 64'd0);

    // Reset during the stop bit of the second byte.
    clear_mon();
    @(negedge clock);
    base_adr = AW'($urandom); word_count = 15'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    timeout = 0;
    while (rx_q.size() < 2 && timeout < 200) begin
      @(negedge clock);
      timeout++;
    end
    check("reset_wait_timeout", 64'(timeout < 200), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_tx", 64'(tx), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_rd_en", 64'(mem_rd_en), 64'd0);
    check("midrst_adr", 64'(mem_adr), 64'd0);
    reset = 1'b0;
    repeat (400) @(negedge clock);
    check("midrst_nbytes", 64'(rx_q.size()), 64'd2);
    check("midrst_nreads", 64'(rd_q.size()), 64'd1);
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    run_dump("after_reset", AW'($urandom), 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
